// File: rtl/sme_matcher.sv
// sme_matcher: string-matching engine on the responder side of the
// chardata/isstring/ispattern character-stream protocol.
//
// A target string is buffered, then any number of patterns are searched
// against it, one candidate start position per cycle.
// Each pattern produces one result strobe.
//
// Pattern syntax:
//   '^'  leading anchor (start of string or after a space)
//   '$'  trailing anchor (end of string or before a space)
//   '.'  any char
//   any other char is a literal
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   chardata     input character, qualified by isstring / ispattern
//   isstring     string character strobe (contiguous run)
//   ispattern    pattern character strobe (contiguous run; falling edge searches)
//   valid        one-cycle result strobe
//   match        1 = pattern found; held until the next valid
//   match_index  string index of the first matched core char; 0 when no match
//
// Build option: define SME_CASE_FOLD_EN for case-insensitive letter compares.
module sme_matcher #(
    parameter int MAX_STR = 32,
    parameter int MAX_PAT = 8,
    parameter int IDX_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       chardata,
    input  logic             isstring,
    input  logic             ispattern,
    output logic             valid,
    output logic             match,
    output logic [IDX_W-1:0] match_index
);

    localparam int LEN_W = $clog2(MAX_STR + 1);
    localparam int PL_W  = $clog2(MAX_PAT + 1);
    localparam int PI_W  = $clog2(MAX_PAT);
    localparam int POS_W = LEN_W + 1;

    typedef enum logic [2:0] {IDLE, LOAD_STR, LOAD_PAT, SEARCH, DONE} state_t;

    state_t           r_state, w_next;
    logic [7:0]       r_str [MAX_STR];
    logic [7:0]       r_pat [MAX_PAT];
    logic [LEN_W-1:0] r_str_len;
    logic [PL_W-1:0]  r_pat_len;
    logic [IDX_W-1:0] r_s;
    logic             r_valid, r_match;
    logic [IDX_W-1:0] r_idx;

    logic             w_str_wr, w_str_clr, w_pat_wr, w_pat_clr;
    logic [LEN_W-1:0] w_str_idx;
    logic [PL_W-1:0]  w_pat_idx;
    logic             w_bol, w_eol, w_hit, w_last;
    logic [PL_W-1:0]  w_core_len;
    logic [POS_W-1:0] w_end;

    function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef SME_CASE_FOLD_EN
        if (c >= 8'h41 && c <= 8'h5A) return c | 8'h20;
        return c;
`else
        return c;
`endif
    endfunction

    function automatic logic char_eq(input logic [7:0] p, input logic [7:0] c);
        return (p == 8'h2E) || (fold(p) == fold(c));
    endfunction

    // A fresh run of string/pattern chars restarts its buffer at index 0.
    assign w_str_idx = w_str_clr ? '0 : r_str_len;
    assign w_pat_idx = w_pat_clr ? '0 : r_pat_len;

    // Anchors are only recognised in their legal positions; elsewhere they are literals.
    assign w_bol      = (r_pat_len != '0) && (r_pat[0] == 8'h5E);
    assign w_eol      = (r_pat_len > PL_W'(w_bol)) &&
                        (r_pat[PI_W'(r_pat_len - 1'b1)] == 8'h24);
    assign w_core_len = r_pat_len - PL_W'(w_bol) - PL_W'(w_eol);
    assign w_end      = POS_W'(r_s) + POS_W'(w_core_len);

    // Compare every core char against the string at start position r_s.
    always_comb begin
        w_hit = (w_core_len != '0);
        for (int k = 0; k < MAX_PAT; k++) begin
            if (PL_W'(k) < w_core_len) begin
                if ((POS_W'(r_s) + POS_W'(k)) >= POS_W'(r_str_len))
                    w_hit = 1'b0;
                else if (!char_eq(r_pat[PI_W'(k) + PI_W'(w_bol)],
                                  r_str[IDX_W'(POS_W'(r_s) + POS_W'(k))]))
                    w_hit = 1'b0;
            end
        end
        if (w_bol && (r_s != '0) && (r_str[r_s - 1'b1] != 8'h20))
            w_hit = 1'b0;
        if (w_eol && (w_end < POS_W'(r_str_len)) && (r_str[IDX_W'(w_end)] != 8'h20))
            w_hit = 1'b0;
    end

    // Last candidate reached (or no candidate exists at all).
    assign w_last = (w_core_len == '0) ||
                    (LEN_W'(w_core_len) > r_str_len) ||
                    (w_end >= POS_W'(r_str_len));

    always_comb begin
        w_next    = r_state;
        w_str_wr  = 1'b0;
        w_str_clr = 1'b0;
        w_pat_wr  = 1'b0;
        w_pat_clr = 1'b0;
        case (r_state)
            IDLE: begin
                if (isstring) begin
                    w_next = LOAD_STR; w_str_wr = 1'b1; w_str_clr = 1'b1;
                end else if (ispattern) begin
                    w_next = LOAD_PAT; w_pat_wr = 1'b1; w_pat_clr = 1'b1;
                end
            end
            LOAD_STR: begin
                if (isstring) begin
                    w_str_wr = 1'b1;
                end else if (ispattern) begin
                    // Pattern immediately following the string: no char lost.
                    w_next = LOAD_PAT; w_pat_wr = 1'b1; w_pat_clr = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            LOAD_PAT: begin
                if (ispattern) w_pat_wr = 1'b1;
                else           w_next   = SEARCH;
            end
            SEARCH, DONE: begin
                // A new string aborts any search in flight; stray pattern chars are ignored.
                if (isstring) begin
                    w_next = LOAD_STR; w_str_wr = 1'b1; w_str_clr = 1'b1;
                end else if (r_state == DONE) begin
                    w_next = IDLE;
                end else if (w_hit || w_last) begin
                    w_next = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_str_len <= '0;
            r_pat_len <= '0;
            r_s       <= '0;
            r_valid   <= 1'b0;
            r_match   <= 1'b0;
            r_idx     <= '0;
        end else begin
            r_state <= w_next;
            if (w_str_wr && (w_str_idx < LEN_W'(MAX_STR)))
                r_str_len <= w_str_idx + 1'b1;
            if (w_pat_wr && (w_pat_idx < PL_W'(MAX_PAT)))
                r_pat_len <= w_pat_idx + 1'b1;
            r_s     <= (r_state == SEARCH) ? r_s + 1'b1 : '0;
            r_valid <= (r_state == SEARCH) && (w_next == DONE);
            if ((r_state == SEARCH) && (w_next == DONE)) begin
                r_match <= w_hit;
                r_idx   <= w_hit ? r_s : '0;
            end
        end
    end

    // Character storage carries no reset; the length registers qualify it.
    always_ff @(posedge clk) begin
        if (w_str_wr && (w_str_idx < LEN_W'(MAX_STR)))
            r_str[w_str_idx[IDX_W-1:0]] <= chardata;
        if (w_pat_wr && (w_pat_idx < PL_W'(MAX_PAT)))
            r_pat[w_pat_idx[PI_W-1:0]] <= chardata;
    end

    assign valid       = r_valid;
    assign match       = r_match;
    assign match_index = r_idx;

endmodule

// File: tb/tb_sme_matcher.sv
module tb_sme_matcher;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] chardata;
    logic       isstring, ispattern;
    logic       valid, match;
    logic [4:0] match_index;

    sme_matcher #(.MAX_STR(32), .MAX_PAT(8), .IDX_W(5)) dut (
        .clk(clk), .reset(reset), .chardata(chardata),
        .isstring(isstring), .ispattern(ispattern),
        .valid(valid), .match(match), .match_index(match_index)
    );

    always #5 clk = ~clk;

    typedef struct { bit m; int idx; string name; } exp_t;
    typedef struct { string s; string p; bit m; int idx; } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cur_len = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every result strobe must correspond to a pushed expectation.
    always @(posedge clk) begin
        #1;
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got valid=1 expected no result");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_match"}, int'(match), int'(e.m));
                chk({e.name, "_index"}, int'(match_index), e.idx);
            end
        end
    end

    task automatic send(input string s, input bit is_pat);
        for (int i = 0; i < s.len(); i++) begin
            chardata = s[i];
            if (is_pat) ispattern = 1'b1;
            else        isstring  = 1'b1;
            @(negedge clk);
        end
        isstring  = 1'b0;
        ispattern = 1'b0;
        chardata  = 8'h00;
    endtask

    task automatic load_str(input string s);
        send(s, 1'b0);
        cur_len = (s.len() > 32) ? 32 : s.len();
        @(negedge clk);
    endtask

    task automatic run_pat(input string p, input bit m, input int idx, input int budget);
        exp_t e;
        bit   done;
        e.m = m; e.idx = idx; e.name = p;
        sb.push_back(e);
        send(p, 1'b1);
        done = 1'b0;
        for (int c = 1; c <= budget && !done; c++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0) done = 1'b1;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_latency: got no valid within %0d cycles expected valid", p, budget);
            sb.delete();
        end else begin
            @(posedge clk);
            #2;
            chk({p, "_pulse"}, int'(valid), 0);
        end
        @(negedge clk);
    endtask

    task automatic add(input string s, input string p, input bit m, input int idx);
        vec_t v;
        v.s = s; v.p = p; v.m = m; v.idx = idx;
        vecs.push_back(v);
    endtask

    initial begin
        string s31b, s32c, s32a;
        bit    seen;

        reset = 1'b0; chardata = 8'h00; isstring = 1'b0; ispattern = 1'b0;
        add("hello world", "o.w",     1, 4);
        add("",            "wor",     1, 6);
        add("",            "lo$",     1, 3);
        add("",            "ld$",     1, 9);
        add("",            "^wor",    1, 6);
        add("",            "^ell",    0, 0);
        add("",            "^hello$", 1, 0);
        add("",            "xyz",     0, 0);
        add("",            "^",       0, 0);
        add("",            "^$",      0, 0);
        add("",            "hello woZZZ", 1, 0);
        add("",            "l.o",     1, 2);

        repeat (3) @(negedge clk);
        chk("rst_valid", int'(valid), 0);
        chk("rst_match", int'(match), 0);
        chk("rst_index", int'(match_index), 0);
        reset = 1'b1;
        @(negedge clk);

        run_pat("ab", 0, 0, 5);

        foreach (vecs[i]) begin
            if (vecs[i].s.len() != 0) load_str(vecs[i].s);
            run_pat(vecs[i].p, vecs[i].m, vecs[i].idx, cur_len + 3);
        end
        repeat (3) @(negedge clk);
        chk("hold_match", int'(match), 1);
        chk("hold_index", int'(match_index), 2);

        s31b = "";
        for (int i = 0; i < 31; i++) s31b = {s31b, "a"};
        s32a = {s31b, "a"};
        s31b = {s31b, "b"};
        s32c = {s31b, "c"};
        load_str(s31b);
        run_pat("ab", 1, 30, 35);
        load_str(s32c);
        run_pat("b$", 1, 31, 35);

        // Asynchronous reset in the middle of a long search.
        load_str(s32a);
        send("b", 1'b1);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_match", int'(match), 0);
        chk("midrst_index", int'(match_index), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
        end
        chk("midrst_no_valid", int'(seen), 0);
        cur_len = 0;
        run_pat("a", 0, 0, 5);
        load_str("xyz");
        run_pat("yz", 1, 1, 6);

        // A new string during a search aborts it without a result.
        for (int i = 0; i < 20; i++) s32a = (i == 0) ? "a" : {s32a, "a"};
        load_str(s32a.substr(0, 19));
        send("b", 1'b1);
        repeat (3) @(negedge clk);
        send("cat", 1'b0);
        cur_len = 3;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
        end
        chk("abort_no_valid", int'(seen), 0);
        run_pat("at", 1, 1, 6);

        load_str("Hello");
`ifdef SME_CASE_FOLD_EN
        run_pat("hEL", 1, 0, 8);
`else
        run_pat("hEL", 0, 0, 8);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
